// File: rtl/mem_stage_sram_ctrl_pkg.sv
// rtl/mem_stage_sram_ctrl_pkg.sv - shared widths, address map and FSM encoding for the MEM-stage SRAM controller
package mem_stage_sram_ctrl_pkg;

  localparam int WORD_LEN    = 32;
  localparam int SRAM_ADDR_W = 18;
  localparam int BASE_ADDR   = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  // Word index inside the SRAM; wraps modulo the SRAM size, byte offset dropped.
  function automatic logic [SRAM_ADDR_W-2:0] word_idx(input logic [WORD_LEN-1:0] addr);
    logic [WORD_LEN-1:0] off;
    off = addr - WORD_LEN'(BASE_ADDR);
    return off[SRAM_ADDR_W:2];
  endfunction

endpackage

// File: rtl/mem_stage_sram_ctrl_if.sv
// rtl/mem_stage_sram_ctrl_if.sv - EXE/MEM memory request bus between pipeline and SRAM controller
interface mem_stage_sram_ctrl_if;
  import mem_stage_sram_ctrl_pkg::*;

  logic                rd_en;
  logic                wr_en;
  logic [WORD_LEN-1:0] address;
  logic [WORD_LEN-1:0] write_data;
  logic [WORD_LEN-1:0] read_data;
  logic                ready;

  modport master (
    output rd_en, wr_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  rd_en, wr_en, address, write_data,
    output read_data, ready
  );

endinterface

// File: rtl/mem_stage_sram_ctrl_sram_phase_timer.sv
// rtl/mem_stage_sram_ctrl_sram_phase_timer.sv - per-phase wait counter with clear and terminal flag
module sram_phase_timer #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic term
);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= 4'd0;
    end else begin
      cnt <= cnt + 4'd1;
    end
  end

  assign term = (cnt == 4'(WAIT_CYCLES - 1));

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// rtl/mem_stage_sram_ctrl.sv - executes EXE/MEM loads/stores as two half-word accesses on a 16-bit async SRAM
module mem_stage_sram_ctrl
  import mem_stage_sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_stage_sram_ctrl_if.slave   bus,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_o,
  input  logic [15:0]            sram_dq_i,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n,
  output logic                   sram_oe_n
);

  state_t                 state, state_nxt;
  logic                   op_wr, op_wr_nxt;
  logic                   term, phase_clr, phase_end;
  logic                   req;
  logic [SRAM_ADDR_W-2:0] idx;
  logic [WORD_LEN-1:0]    read_data;

  assign req           = bus.rd_en | bus.wr_en;
  assign idx           = word_idx(bus.address);
  assign phase_end     = term && (state == LO || state == HI);
  assign bus.ready     = !(req && state != DONE);
  assign bus.read_data = read_data;

  sram_phase_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (phase_clr),
    .term (term)
  );

  always_comb begin
    state_nxt = state;
    op_wr_nxt = op_wr;
    phase_clr = 1'b1;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = LO;
          op_wr_nxt = bus.wr_en;
        end
      end
      LO: begin
        phase_clr = term;
        if (term) state_nxt = HI;
      end
      HI: begin
        phase_clr = term;
        if (term) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pins are loaded from the state being entered so strobes only move on clock edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_wr      <= 1'b0;
      read_data  <= '0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_we_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
    end else begin
      state <= state_nxt;
      op_wr <= op_wr_nxt;
      if (phase_end && !op_wr) begin
        if (state == LO) read_data[15:0]  <= sram_dq_i;
        else             read_data[31:16] <= sram_dq_i;
      end
      if (state_nxt == LO || state_nxt == HI) begin
        sram_addr <= {idx, (state_nxt == HI)};
        if (op_wr_nxt) begin
          sram_dq_o <= (state_nxt == HI) ? bus.write_data[31:16] : bus.write_data[15:0];
        end
        sram_dq_oe <= op_wr_nxt;
        sram_we_n  <= !op_wr_nxt;
        sram_oe_n  <= op_wr_nxt;
      end else begin
        sram_dq_oe <= 1'b0;
        sram_we_n  <= 1'b1;
        sram_oe_n  <= 1'b1;
      end
    end
  end

endmodule

// File: doc/mem_stage_sram_ctrl.md
Name: mem_stage_sram_ctrl

Overview:
- Consumer end of the EXE/MEM pipeline register. Takes the registered memory request from EXE/MEM (MEM_R_EN, MEM_W_EN, ALURes as address, STVal as store data) and executes it on an external 16-bit asynchronous SRAM.
- Each 32-bit word needs two half-word accesses, each lasting WAIT_CYCLES clocks.
- Drives ready low while an access is in flight; the hazard/freeze logic uses ready to stall every pipeline register up to and including EXE/MEM.

Parameters:
- WORD_LEN, 32, CPU data/address width
- SRAM_ADDR_W, 18, SRAM half-word address width
- BASE_ADDR, 1024, CPU byte address mapped to SRAM half-word 0
- WAIT_CYCLES, 2, clocks per half-word access; legal range 1..15

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- rd_en  in  1  load request (MEM_R_EN from EXE/MEM)
- wr_en  in  1  store request (MEM_W_EN from EXE/MEM)
- address  in  WORD_LEN  byte address (ALURes from EXE/MEM)
- write_data  in  WORD_LEN  store data (STVal from EXE/MEM)
- read_data  out  WORD_LEN  loaded word, registered
- ready  out  1  high = no access pending or access completing this cycle
- sram_addr  out  SRAM_ADDR_W  half-word address
- sram_dq_o  out  16  SRAM write data
- sram_dq_i  in  16  SRAM read data
- sram_dq_oe  out  1  tri-state enable for sram_dq_o; the top level drives the pad
- sram_we_n  out  1  active-low write strobe
- sram_oe_n  out  1  active-low output enable

Behaviour:
- Address translation:
  - idx = ((address - BASE_ADDR) >> 2), truncated to SRAM_ADDR_W-1 bits, so out-of-range addresses wrap modulo the SRAM size.
  - address[1:0] is ignored.
  - Low half-word at sram_addr = {idx,1'b0}; high half-word at {idx,1'b1}.
- FSM states: IDLE, LO, HI, DONE. A counter cnt runs 0..WAIT_CYCLES-1 within LO and HI.
- IDLE:
  - If rd_en|wr_en is high, latch op (write if wr_en, else read), go to LO, cnt=0.
  - If rd_en and wr_en are both high, the request is treated as a write.
- LO:
  - sram_addr = low address.
  - Write: sram_dq_o = write_data[15:0], sram_dq_oe=1, sram_we_n=0.
  - Read: sram_oe_n=0.
  - When cnt==WAIT_CYCLES-1: a read captures sram_dq_i into read_data[15:0]; the FSM goes to HI with cnt=0. Otherwise cnt increments.
- HI: same as LO using the high address, write_data[31:16] and read_data[31:16]; exits to DONE.
- DONE: ready=1 and read_data holds the full word. The pipeline advances on this edge and the FSM goes unconditionally to IDLE.
- Timing: a request first seen in IDLE at cycle t gives ready=1 in cycle t+2*WAIT_CYCLES+1. ready=0 from cycle t through t+2*WAIT_CYCLES.
- ready = !( (rd_en|wr_en) && state!=DONE ). With no request, ready=1 combinationally.
- Inputs are guaranteed stable while ready=0 because the pipeline is frozen. Changing them mid-access has no effect; the op is latched at IDLE and address/data are sampled each phase.
- read_data changes only on read captures. Writes leave it unchanged.
- Back-to-back requests: the IDLE cycle after DONE is mandatory. A new request there starts LO on the next edge.
- SRAM strobes (sram_we_n, sram_oe_n, sram_dq_oe) are registered and change only on clk edges.
- Reset, applied in any state including mid-access:
  - state=IDLE, cnt=0, read_data=0, sram_addr=0, sram_dq_o=0, sram_dq_oe=0, sram_we_n=1, sram_oe_n=1.
  - An aborted write may leave a partially written word; this is accepted.

Decomposition:
- Shared package/defines:
  - WORD_LEN
  - BASE_ADDR
  - state encoding IDLE=2'd0, LO=2'd1, HI=2'd2, DONE=2'd3
  - SRAM_ADDR_W
- Sub-module sram_phase_timer: a WAIT_CYCLES down/up counter with clear and a terminal pulse, instantiated once and cleared on each phase entry.

Test Plan:
- Reset: rst=1 for 2 cycles in the LO state of an in-flight write -> next cycle state IDLE, sram_we_n=1, sram_dq_oe=0, read_data=0, ready=1.
- Store, WAIT_CYCLES=2: wr_en=1, address=1028, write_data=32'hDEADBEEF, cycle 0 ->
  - cycles 1-2: sram_addr=2, dq=BEEF
  - cycles 3-4: sram_addr=3, dq=DEAD
  - ready=0 cycles 0-4, ready=1 cycle 5
- Load of the same address, sram model returning the stored halves -> read_data=32'hDEADBEEF in cycle 5, ready=1 only in cycle 5.
- Simultaneous rd_en=wr_en=1, address=1024, write_data=32'h00010002 -> write performed: sram_addr 0 gets 0002, sram_addr 1 gets 0001; read_data unchanged.
- Back-to-back: load at 1032 immediately followed by store at 1036 -> second access starts LO exactly 2 cycles after the first DONE; no strobe glitch between them.
- Wrap: address=BASE_ADDR-4 -> idx=all ones; sram_addr=18'h3FFFE then 18'h3FFFF.
